// File: rtl/lcd_pkg.sv
// Shared types and constants for the 84x48 Nokia 5110 LCD framebuffer.
// The panel is column organised: one 48-bit word per pixel column, row 0 in the MSB.
package lcd_pkg;

  localparam int LCD_W  = 84;
  localparam int LCD_H  = 48;
  localparam int LCD_AW = 7;
  localparam int LCD_YW = 6;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } fb_state_t;

  typedef logic [LCD_H-1:0] fb_word_t;

endpackage

// File: rtl/fb_ram.sv
// Column storage for the framebuffer: one synchronous write port and two
// synchronous read-first read ports (display and read-modify-write).
// Contents are not reset so the array maps onto block RAM; only the display
// output register is reset, so the controller sees zeros after reset.
module fb_ram #(
  parameter int WORDS  = 84,
  parameter int WORD_W = 48,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     dispAddr_i,
  input  logic [WORD_W-1:0] dispMask_i,
  output logic [WORD_W-1:0] dispData_o,
  input  logic [AW-1:0]     rmwAddr_i,
  output logic [WORD_W-1:0] rmwData_o
);

  localparam logic [AW-1:0] NUM_WORDS = AW'(WORDS);

  logic [WORD_W-1:0] mem [WORDS];

  // Single write port shared by the clear sweep and the pixel merge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Display read port: old data on a same-address write, zeros outside the panel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dispData_o <= '0;
    end else if (dispAddr_i < NUM_WORDS) begin
      dispData_o <= mem[dispAddr_i] ^ dispMask_i;
    end else begin
      dispData_o <= '0;
    end
  end

  // Read port feeding the pixel merge; the address is always a validated column.
  always_ff @(posedge clk) begin
    rmwData_o <= mem[rmwAddr_i];
  end

endmodule

// File: rtl/lcd_framebuffer.sv
// Pixel framebuffer for the 84x48 Nokia 5110 LCD. Single pixels arrive over a
// valid/ready handshake and are merged into column words by read-modify-write;
// the display controller reads whole columns through an independent port.
// The buffer is swept to zero after reset and whenever clr_req is seen in IDLE.
// Optional build macro FB_INVERT_EN adds an 'invert' input that inverts display
// read data without touching memory contents.
module lcd_framebuffer
  import lcd_pkg::*;
#(
  parameter int WORDS  = LCD_W,
  parameter int WORD_W = LCD_H,
  parameter int AW     = LCD_AW,
  parameter int YW     = LCD_YW
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [AW-1:0]     px_x,
  input  logic [YW-1:0]     px_y,
  input  logic              px_val,
  output logic              px_drop,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [AW-1:0]     rd_addr,
`ifdef FB_INVERT_EN
  input  logic              invert,
`endif
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [AW-1:0]     NUM_WORDS = AW'(WORDS);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(WORDS - 1);
  localparam logic [YW-1:0]     NUM_ROWS  = YW'(WORD_W);
  localparam logic [WORD_W-1:0] MSB_MASK  = {1'b1, {(WORD_W-1){1'b0}}};

  fb_state_t         state_q, state_d;
  logic [AW-1:0]     clrCnt_q, clrCnt_d;
  logic [AW-1:0]     pxX_q, pxX_d;
  logic [YW-1:0]     pxY_q, pxY_d;
  logic              pxVal_q, pxVal_d;
  logic              pxDrop_q, pxDrop_d;

  logic              ramWe;
  logic [AW-1:0]     ramWaddr;
  logic [WORD_W-1:0] ramWdata;
  logic [WORD_W-1:0] rmwData;
  logic [WORD_W-1:0] dispMask;
  logic [WORD_W-1:0] bitMask;
  logic [WORD_W-1:0] mergedWord;
  logic              outOfRange;

`ifdef FB_INVERT_EN
  assign dispMask = {WORD_W{invert}};
`else
  assign dispMask = '0;
`endif

  assign outOfRange = (px_x >= NUM_WORDS) || (px_y >= NUM_ROWS);
  assign bitMask    = MSB_MASK >> pxY_q;
  assign mergedWord = pxVal_q ? (rmwData | bitMask) : (rmwData & ~bitMask);

  assign px_ready = (state_q == IDLE) && !clr_req;
  assign clr_busy = (state_q == CLEAR);
  assign px_drop  = pxDrop_q;

  fb_ram #(
    .WORDS (WORDS),
    .WORD_W(WORD_W),
    .AW    (AW)
  ) uRam (
    .clk       (clk),
    .nrst      (nrst),
    .we_i      (ramWe),
    .waddr_i   (ramWaddr),
    .wdata_i   (ramWdata),
    .dispAddr_i(rd_addr),
    .dispMask_i(dispMask),
    .dispData_o(rd_data),
    .rmwAddr_i (pxX_q),
    .rmwData_o (rmwData)
  );

  // State and pixel-latch registers; reset abandons any merge and restarts the sweep.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
      pxX_q    <= '0;
      pxY_q    <= '0;
      pxVal_q  <= 1'b0;
      pxDrop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      pxX_q    <= pxX_d;
      pxY_q    <= pxY_d;
      pxVal_q  <= pxVal_d;
      pxDrop_q <= pxDrop_d;
    end
  end

  // Next-state logic: clear sweep, pixel acceptance and the two-cycle merge.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    pxX_d    = pxX_q;
    pxY_d    = pxY_q;
    pxVal_d  = pxVal_q;
    pxDrop_d = 1'b0;
    ramWe    = 1'b0;
    ramWaddr = pxX_q;
    ramWdata = mergedWord;

    unique case (state_q)
      CLEAR: begin
        ramWe    = 1'b1;
        ramWaddr = clrCnt_q;
        ramWdata = '0;
        if (clrCnt_q == LAST_ADDR) begin
          clrCnt_d = '0;
          state_d  = IDLE;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
        end else if (px_valid) begin
          if (outOfRange) begin
            pxDrop_d = 1'b1;
          end else begin
            pxX_d   = px_x;
            pxY_d   = px_y;
            pxVal_d = px_val;
            state_d = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        state_d = RMW_WR;
      end
      RMW_WR: begin
        ramWe   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_framebuffer.sv
// Self-checking bench for lcd_framebuffer. A reference image of the panel is
// kept in the bench; expected read words are queued when a read is issued and
// compared when the registered read data appears.
module tb_lcd_framebuffer;

  localparam int WORDS  = 84;
  localparam int WORD_W = 48;

  logic              clk = 1'b0;
  logic              nrst;
  logic              px_valid;
  logic              px_ready;
  logic [6:0]        px_x;
  logic [5:0]        px_y;
  logic              px_val;
  logic              px_drop;
  logic              clr_req;
  logic              clr_busy;
  logic [6:0]        rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              invertBit;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0] model [WORDS];
  logic [WORD_W-1:0] expQ [$];

  always #5 clk = ~clk;

  lcd_framebuffer dut (
    .clk     (clk),
    .nrst    (nrst),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .px_x    (px_x),
    .px_y    (px_y),
    .px_val  (px_val),
    .px_drop (px_drop),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .rd_addr (rd_addr),
`ifdef FB_INVERT_EN
    .invert  (invertBit),
`endif
    .rd_data (rd_data)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < WORDS; i++) model[i] = '0;
  endtask

  // Issue a display read, queue its expected word, compare one cycle later.
  task automatic readExpect(input int addr, input logic [WORD_W-1:0] exp);
    logic [WORD_W-1:0] e;
    rd_addr = 7'(addr);
    expQ.push_back(exp);
    @(posedge clk); #1;
    e = expQ.pop_front();
    checkOutput($sformatf("rdData[%0d]", addr), rd_data, e);
  endtask

  task automatic readModel(input int addr);
    logic [WORD_W-1:0] e;
    if (addr < WORDS) e = model[addr] ^ {WORD_W{invertBit}};
    else e = '0;
    readExpect(addr, e);
  endtask

  task automatic readAll();
    for (int i = 0; i < WORDS; i++) readModel(i);
  endtask

  // Count sampled clr_busy cycles; optionally pulse clr_req mid-sweep.
  task automatic waitClear(input string tag, input bit pulseReq);
    int n;
    n = 0;
    while (clr_busy && n < 300) begin
      n++;
      if (pulseReq && n == 10) clr_req = 1'b1;
      if (pulseReq && n == 11) clr_req = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput(tag, WORD_W'(n), WORD_W'(84));
    checkOutput({tag, "Ready"}, WORD_W'(px_ready), WORD_W'(1));
    clearModel();
  endtask

  // Drive one pixel through the handshake and check the accept/drop timing.
  task automatic applyStimulus(input int x, input int y, input bit v);
    int n;
    px_x     = 7'(x);
    px_y     = 6'(y);
    px_val   = v;
    px_valid = 1'b1;
    n = 0;
    while (!px_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!px_ready) begin
      checkOutput("readyTimeout", WORD_W'(px_ready), WORD_W'(1));
      px_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    px_valid = 1'b0;
    if (x < WORDS && y < WORD_W) begin
      model[x][WORD_W-1-y] = v;
      checkOutput("readyLow1", WORD_W'(px_ready), WORD_W'(0));
      checkOutput("noDrop", WORD_W'(px_drop), WORD_W'(0));
      @(posedge clk); #1;
      checkOutput("readyLow2", WORD_W'(px_ready), WORD_W'(0));
      @(posedge clk); #1;
      checkOutput("readyBack", WORD_W'(px_ready), WORD_W'(1));
    end else begin
      checkOutput("dropPulse", WORD_W'(px_drop), WORD_W'(1));
      checkOutput("dropReady", WORD_W'(px_ready), WORD_W'(1));
      @(posedge clk); #1;
      checkOutput("dropEnd", WORD_W'(px_drop), WORD_W'(0));
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    logic [WORD_W-1:0] oldWord;
    nrst      = 1'b0;
    px_valid  = 1'b0;
    px_x      = '0;
    px_y      = '0;
    px_val    = 1'b0;
    clr_req   = 1'b0;
    rd_addr   = '0;
    invertBit = 1'b0;
    clearModel();

    #3;
    checkOutput("rstRdData", rd_data, '0);
    checkOutput("rstReady", WORD_W'(px_ready), WORD_W'(0));
    checkOutput("rstBusy", WORD_W'(clr_busy), WORD_W'(1));
    checkOutput("rstDrop", WORD_W'(px_drop), WORD_W'(0));
    @(posedge clk); #1;
    nrst = 1'b1;
    waitClear("resetClear", 1'b0);
    readAll();

    $display("[TB] corner pixels");
    applyStimulus(0, 0, 1'b1);
    applyStimulus(83, 47, 1'b1);
    readExpect(0, 48'h800000000000);
    readExpect(83, 48'h000000000001);

    $display("[TB] same-word back-to-back");
    applyStimulus(5, 8, 1'b1);
    applyStimulus(5, 9, 1'b1);
    applyStimulus(5, 8, 1'b0);
    readExpect(5, 48'h004000000000);

    $display("[TB] out-of-range pixels");
    applyStimulus(84, 0, 1'b1);
    applyStimulus(3, 48, 1'b1);
    readExpect(84, '0);
    readExpect(127, '0);
    readModel(3);
    readModel(0);

    $display("[TB] read-first on same address");
    rd_addr = 7'd20;
    oldWord = model[20];
    applyStimulus(20, 3, 1'b1);
    checkOutput("readFirstOld", rd_data, oldWord);
    @(posedge clk); #1;
    checkOutput("readFirstNew", rd_data, model[20]);

    $display("[TB] random pixels");
    for (int i = 0; i < 10; i++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 90));
      ry = int'($urandom_range(0, 52));
      applyStimulus(rx, ry, 1'($urandom_range(0, 1)));
      readModel(rx);
    end

    $display("[TB] clear request racing a pixel");
    applyStimulus(7, 7, 1'b1);
    applyStimulus(40, 20, 1'b1);
    readModel(40);
    px_x     = 7'd9;
    px_y     = 6'd1;
    px_val   = 1'b1;
    px_valid = 1'b1;
    clr_req  = 1'b1;
    #1;
    checkOutput("clrBlocksReady", WORD_W'(px_ready), WORD_W'(0));
    @(posedge clk); #1;
    clr_req  = 1'b0;
    px_valid = 1'b0;
    checkOutput("clrEntered", WORD_W'(clr_busy), WORD_W'(1));
    waitClear("reqClear", 1'b1);
    readAll();

    $display("[TB] reset during read-modify-write");
    applyStimulus(0, 0, 1'b1);
    readModel(0);
    rd_addr  = 7'd0;
    px_x     = 7'd10;
    px_y     = 6'd5;
    px_val   = 1'b1;
    px_valid = 1'b1;
    @(posedge clk); #1;
    px_valid = 1'b0;
    nrst = 1'b0;
    #1;
    checkOutput("midRstRdData", rd_data, '0);
    checkOutput("midRstBusy", WORD_W'(clr_busy), WORD_W'(1));
    checkOutput("midRstReady", WORD_W'(px_ready), WORD_W'(0));
    @(posedge clk); #1;
    nrst = 1'b1;
    waitClear("midRstClear", 1'b0);
    readModel(10);
    readModel(0);

`ifdef FB_INVERT_EN
    $display("[TB] inverted display read");
    invertBit = 1'b1;
    applyStimulus(1, 0, 1'b1);
    readExpect(1, 48'h7FFFFFFFFFFF);
    readExpect(84, '0);
    readModel(2);
    invertBit = 1'b0;
    readExpect(1, 48'h800000000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_framebuffer.md
Name: lcd_framebuffer

Overview:
Pixel framebuffer for the 84x48 Nokia 5110 LCD, directly upstream of the SPI display controller. A drawing source writes single pixels through a valid/ready handshake; the block performs read-modify-write into column-organised 48-bit words. The display controller reads whole columns through a registered read port (rd_addr/rd_data). After reset, and on request, the block clears the whole buffer.

Parameters:
WORDS, 84, number of 48-bit column words (LCD width)
WORD_W, 48, bits per word (LCD height)
AW, 7, address and x-coordinate width
YW, 6, y-coordinate width

Ports:
clk  in  1  system clock
nrst  in  1  reset
px_valid  in  1  pixel write request
px_ready  out  1  pixel write accepted when px_valid && px_ready
px_x  in  AW  pixel column, 0..WORDS-1
px_y  in  YW  pixel row, 0..WORD_W-1
px_val  in  1  pixel value (1 = dark)
px_drop  out  1  one-cycle pulse: the accepted pixel was out of range and was discarded
clr_req  in  1  request a full-buffer clear (level-sampled)
clr_busy  out  1  clear sweep in progress
rd_addr  in  AW  display read address
rd_data  out  WORD_W  word at rd_addr, registered

Behaviour:
- Reset nrst is asynchronous and active-low; clock is clk. Reset values: state=CLEAR, clear counter=0, px_ready=0, clr_busy=1, px_drop=0, rd_data=0.
- Mapping: word index = px_x. Bit index = WORD_W-1-px_y, so row 0 is the MSB and rd_data[47:40] holds rows 0..7.
- Read port: rd_data <= mem[rd_addr] on every clk; latency is 1 cycle. If rd_addr >= WORDS, rd_data <= 0. Read-first: a same-cycle write to the same address returns the old data.
- FSM states: CLEAR, IDLE, RMW_RD, RMW_WR.
- CLEAR: writes 0 to address clr_cnt, then clr_cnt++. Leaves for IDLE after writing address WORDS-1 and resets clr_cnt to 0. clr_busy=1 throughout. clr_req is ignored while in CLEAR.
- IDLE: px_ready = (state==IDLE) && !clr_req, combinational.
  - If clr_req=1, go to CLEAR. Clear wins a same-cycle pixel request; that pixel is not accepted.
  - Else, on handshake with px_x >= WORDS or px_y >= WORD_W: pixel is discarded, px_drop pulses the next cycle, state stays IDLE.
  - Else, on a valid handshake: latch x, y and val, then go to RMW_RD.
- RMW_RD: internal read of mem[x]; the result is available next cycle.
- RMW_WR: write mem[x] with bit (WORD_W-1-y) set to val; all other bits are unchanged. Return to IDLE.
- Pixel throughput is one pixel per 3 cycles. px_ready is low in RMW_RD, RMW_WR and CLEAR.
- Back-to-back writes to the same word are correct because each RMW completes before the next one is accepted.
- A clr_req arriving during RMW_RD or RMW_WR is not lost: it is seen in the following IDLE cycle, provided the requester holds it high until clr_busy rises.
- The display read port is independent of the FSM and is never stalled, including during CLEAR. Display data read during a sweep may be partially cleared.
- Reset mid-operation: any in-flight RMW is abandoned and a full clear restarts.

Optional Feature:
- Macro FB_INVERT_EN.
- When defined: adds input port invert (1 bit). rd_data is registered as mem[rd_addr] XOR {WORD_W{invert}}, with invert sampled in the same cycle as rd_addr. Out-of-range addresses still return all zeros. Memory contents are never modified.
- When undefined: no invert port; rd_data is the raw word.

Decomposition:
- Package lcd_pkg:
  - LCD_W=84, LCD_H=48 localparams.
  - fb_state_t enum {CLEAR, IDLE, RMW_RD, RMW_WR}.
  - Typedef fb_word_t = logic [LCD_H-1:0].
- Sub-module fb_ram:
  - WORDS x WORD_W storage, no reset on contents.
  - One synchronous write port.
  - Two synchronous read-first read ports: display and RMW.
  - Inferable as block RAM.
- lcd_framebuffer holds the FSM, clear counter, range check and bit merge.

Test Plan:
- Reset, then hold nrst=1: clr_busy=1 for exactly 84 cycles, then px_ready=1; reading every address 0..83 returns 48'h0.
- Write px(0,0,1), then px(83,47,1): rd_addr=0 -> 48'h800000000000; rd_addr=83 -> 48'h000000000001; px_ready low for 2 cycles after each handshake.
- Write px(5,8,1), px(5,9,1), px(5,8,0) back-to-back: rd_addr=5 -> 48'h004000000000.
- px(84,0,1) and px(3,48,1): px_drop pulses once each, memory unchanged, rd_addr=84 -> 0.
- clr_req and px_valid asserted in the same IDLE cycle: no handshake, CLEAR entered, all words 0 afterwards; clr_req pulsed during CLEAR does not extend the sweep beyond 84 cycles.
- FB_INVERT_EN defined: after px(1,0,1) with invert=1, rd_addr=1 -> 48'h7FFFFFFFFFFF; nrst asserted mid-RMW -> rd_data=0 and a full clear restarts.
